a2f_stream_arbiter: RTL

- Schedules several sample/telemetry source FIFOs onto the single A2F FIFO that feeds the FT600 write path.
- Grants whole bursts round-robin and prefixes each burst with a 32-bit header word, so the host can demultiplex channels and detect lost bursts.
- Sits between the per-channel source FIFOs and the A2F FIFO write port, in the same clock domain as the A2F write side.

---
 rtl/a2f_stream_arbiter_if.sv | 21 ++
 rtl/a2f_stream_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/a2f_stream_arbiter_if.sv
// Sink-side bundle between the stream arbiter and the A2F FIFO write port.
// The arbiter uses the master modport; the A2F FIFO side uses the slave modport.
interface a2f_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sink_space_ok;
  logic                  a2f_wr_req;
  logic [DATA_WIDTH-1:0] a2f_wdata;

  modport master (
    input  sink_space_ok,
    output a2f_wr_req,
    output a2f_wdata
  );

  modport slave (
    output sink_space_ok,
    input  a2f_wr_req,
    input  a2f_wdata
  );
endinterface

// File: rtl/a2f_stream_arbiter.sv
// Round-robin burst arbiter: multiplexes per-channel source FIFOs onto the A2F FIFO with a header per burst.
// Define A2F_ARB_TRAILER_EN to append an XOR-checksum trailer word after each burst.
module a2f_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_burst_ready,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_rd_req,
  a2f_stream_arbiter_if.master         a2f,
  output logic                         busy,
  output logic [3:0]                   cur_ch,
  output logic                         error
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0]     BLEN    = 16'(BURST_LEN);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

`ifdef A2F_ARB_TRAILER_EN
  typedef enum logic [1:0] {IDLE, HEADER, BURST, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, BURST} state_t;
`endif

  state_t                state, state_nx;
  logic [CH_W-1:0]       rr_last, cur_idx, winner, cand;
  logic [15:0]           rd_cnt, wr_cnt;
  logic [7:0]            seq [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_word [NUM_CH];
  logic [NUM_CH-1:0]     eligible;
  logic                  found;
  logic                  rd_en;
`ifdef A2F_ARB_TRAILER_EN
  logic [DATA_WIDTH-1:0] xor_acc;
`endif

  assign cur_idx  = cur_ch[CH_W-1:0];
  assign eligible = ch_enable & ch_burst_ready;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_word[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First eligible channel after the last grant, wrapping around.
  always_comb begin
    winner = rr_last;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(rr_last) + k) % NUM_CH);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    a2f.a2f_wr_req = 1'b0;
    a2f.a2f_wdata  = '0;
    rd_en          = 1'b0;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        if (found && a2f.sink_space_ok) state_nx = HEADER;
      end
      HEADER: begin
        a2f.a2f_wr_req = 1'b1;
        a2f.a2f_wdata  = DATA_WIDTH'({4'hA, cur_ch, seq[cur_idx], BLEN});
        rd_en          = 1'b1;
        busy           = 1'b1;
        state_nx       = BURST;
      end
      BURST: begin
        a2f.a2f_wr_req = 1'b1;
        a2f.a2f_wdata  = ch_word[cur_idx];
        rd_en          = (rd_cnt != 16'd0);
        busy           = 1'b1;
`ifdef A2F_ARB_TRAILER_EN
        if (wr_cnt == 16'd1) state_nx = TRAILER;
`else
        if (wr_cnt == 16'd1) state_nx = IDLE;
`endif
      end
`ifdef A2F_ARB_TRAILER_EN
      TRAILER: begin
        a2f.a2f_wr_req = 1'b1;
        a2f.a2f_wdata  = xor_acc;
        busy           = 1'b1;
        state_nx       = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign ch_rd_req = rd_en ? (NUM_CH'(1) << cur_idx) : '0;

  // The header itself issues the first read, so the burst only needs BURST_LEN-1 more.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= LAST_CH;
      cur_ch  <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      error   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
    end else begin
      if (rd_en && ch_empty[cur_idx]) error <= 1'b1;
      case (state)
        IDLE: begin
          if (state_nx == HEADER) begin
            cur_ch  <= 4'(winner);
            rr_last <= winner;
          end
        end
        HEADER: begin
          rd_cnt <= BLEN - 16'd1;
          wr_cnt <= BLEN;
        end
        BURST: begin
          if (rd_en) rd_cnt <= rd_cnt - 16'd1;
          wr_cnt <= wr_cnt - 16'd1;
          if (wr_cnt == 16'd1) seq[cur_idx] <= seq[cur_idx] + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef A2F_ARB_TRAILER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                xor_acc <= '0;
    else if (state == HEADER) xor_acc <= '0;
    else if (state == BURST)  xor_acc <= xor_acc ^ ch_word[cur_idx];
  end
`endif

endmodule
